// File: rtl/stbuf_bus_responder_pkg.sv
// Shared types and helpers for the store-buffer bus responder.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package stbuf_bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } stbuf_bus_resp_state_t;

  localparam int BUS_BYTES = `REG_DATA_WIDTH / 8;

  function automatic logic size_legal(input logic [`SIZE_WIDTH-1:0] size);
    case (size)
      `SIZE_WIDTH'(1), `SIZE_WIDTH'(2), `SIZE_WIDTH'(4): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stbuf_bus_responder_lane_align.sv
// Byte-lane alignment: write byte enables and rotated data for both beats,
// and right-aligned read data assembled from the two touched words.
module bus_lane_align
  import stbuf_bus_responder_pkg::*;
(
  input  logic [1:0]                 offset,
  input  logic [`SIZE_WIDTH-1:0]     size,
  input  logic [`REG_DATA_WIDTH-1:0] write_data,
  input  logic [`REG_DATA_WIDTH-1:0] word_lo,
  input  logic [`REG_DATA_WIDTH-1:0] word_hi,
  output logic [BUS_BYTES-1:0]       be_lo,
  output logic [BUS_BYTES-1:0]       be_hi,
  output logic [`REG_DATA_WIDTH-1:0] wdata_lo,
  output logic [`REG_DATA_WIDTH-1:0] wdata_hi,
  output logic [`REG_DATA_WIDTH-1:0] read_data
);

  logic [BUS_BYTES-1:0]         size_be;
  logic [2*BUS_BYTES-1:0]       wide_be;
  logic [2*`REG_DATA_WIDTH-1:0] wide_data;
  logic [`REG_DATA_WIDTH-1:0]   size_bits;
  logic [4:0]                   shamt;

  assign shamt = {offset, 3'b000};

  // Illegal sizes yield an all-zero mask, so writes touch nothing and reads return 0.
  always_comb begin
    size_be   = {BUS_BYTES{1'b0}};
    size_bits = {`REG_DATA_WIDTH{1'b0}};
    case (size)
      `SIZE_WIDTH'(1): size_be = 4'b0001;
      `SIZE_WIDTH'(2): size_be = 4'b0011;
      `SIZE_WIDTH'(4): size_be = 4'b1111;
      default:         size_be = 4'b0000;
    endcase
    for (int b = 0; b < BUS_BYTES; b++) begin
      size_bits[8*b +: 8] = {8{size_be[b]}};
    end
    wide_be   = {{BUS_BYTES{1'b0}}, size_be} << offset;
    be_lo     = wide_be[BUS_BYTES-1:0];
    be_hi     = wide_be[2*BUS_BYTES-1:BUS_BYTES];
    wide_data = {{`REG_DATA_WIDTH{1'b0}}, write_data} << shamt;
    wdata_lo  = wide_data[`REG_DATA_WIDTH-1:0];
    wdata_hi  = wide_data[2*`REG_DATA_WIDTH-1:`REG_DATA_WIDTH];
    read_data = `REG_DATA_WIDTH'({word_hi, word_lo} >> shamt) & size_bits;
  end

endmodule

// File: rtl/stbuf_bus_responder.sv
// Memory-side responder for the store buffer bus: round-robin arbitration,
// per-beat latency counter, byte-addressable little-endian memory.
module stbuf_bus_responder
  import stbuf_bus_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
  input  logic [`SIZE_WIDTH-1:0]     stbuf_bus_read_size,
  input  logic                       stbuf_bus_read_req,
  input  logic [`ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  input  logic [`SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  input  logic [`REG_DATA_WIDTH-1:0] stbuf_bus_data,
  input  logic                       stbuf_bus_write_req,
  output logic [`REG_DATA_WIDTH-1:0] bus_stbuf_data,
  output logic                       bus_stbuf_read_ack,
  output logic                       bus_stbuf_write_ack,
  output logic                       bus_error
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  stbuf_bus_resp_state_t state, next_state;
  logic [3:0]                 cnt, next_cnt;
  logic                       last_write, next_last_write;
  logic                       grant_write;
  logic                       beat1_fire, beat2_fire, split, finish;
  logic                       req_write_q;
  logic [IDX_W+1:0]           addr_q;
  logic [`SIZE_WIDTH-1:0]     size_q;
  logic [`REG_DATA_WIDTH-1:0] data_q, lo_word;
  logic [IDX_W-1:0]           widx, widx_next;
  logic [BUS_BYTES-1:0]       be_lo, be_hi;
  logic [`REG_DATA_WIDTH-1:0] wdata_lo, wdata_hi, read_data, word_lo;
  logic                       unused_addr_bits;

  logic [`REG_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Upper address bits alias onto the same words.
  assign unused_addr_bits = ^{stbuf_bus_read_addr[`ADDR_WIDTH-1:IDX_W+2],
                              stbuf_bus_write_addr[`ADDR_WIDTH-1:IDX_W+2]};

  assign widx      = addr_q[IDX_W+1:2];
  assign widx_next = widx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign split     = size_legal(size_q) && ((5'(addr_q[1:0]) + 5'(size_q)) > 5'd4);
  assign finish    = beat2_fire || (beat1_fire && !split);
  assign word_lo   = (state == BEAT1) ? mem[widx] : lo_word;

  bus_lane_align u_align (
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .write_data (data_q),
    .word_lo    (word_lo),
    .word_hi    (mem[widx_next]),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .wdata_lo   (wdata_lo),
    .wdata_hi   (wdata_hi),
    .read_data  (read_data)
  );

  // Next-state, arbitration and beat-strobe logic.
  always_comb begin
    next_state      = state;
    next_cnt        = cnt;
    next_last_write = last_write;
    grant_write     = 1'b0;
    beat1_fire      = 1'b0;
    beat2_fire      = 1'b0;
    case (state)
      IDLE: begin
        if (stbuf_bus_write_req || stbuf_bus_read_req) begin
          grant_write     = stbuf_bus_write_req && (!stbuf_bus_read_req || !last_write);
          next_last_write = grant_write;
          next_state      = BEAT1;
          next_cnt        = 4'(LATENCY - 1);
        end else begin
          next_state = IDLE;
        end
      end
      BEAT1: begin
        if (cnt == 4'd0) begin
          beat1_fire = 1'b1;
          next_state = split ? BEAT2 : RESP;
          next_cnt   = 4'(LATENCY - 1);
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      BEAT2: begin
        if (cnt == 4'd0) begin
          beat2_fire = 1'b1;
          next_state = RESP;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control state, request latch and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      cnt                 <= 4'd0;
      last_write          <= 1'b0;
      req_write_q         <= 1'b0;
      addr_q              <= '0;
      size_q              <= '0;
      data_q              <= '0;
      lo_word             <= '0;
      bus_stbuf_data      <= '0;
      bus_stbuf_read_ack  <= 1'b0;
      bus_stbuf_write_ack <= 1'b0;
      bus_error           <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      last_write <= next_last_write;
      if (state == IDLE && next_state == BEAT1) begin
        req_write_q <= grant_write;
        addr_q      <= grant_write ? stbuf_bus_write_addr[IDX_W+1:0] : stbuf_bus_read_addr[IDX_W+1:0];
        size_q      <= grant_write ? stbuf_bus_write_size : stbuf_bus_read_size;
        data_q      <= stbuf_bus_data;
      end
      if (beat1_fire) begin
        lo_word <= mem[widx];
      end
      if (finish && !req_write_q) begin
        bus_stbuf_data <= read_data;
      end
      bus_stbuf_read_ack  <= finish && !req_write_q;
      bus_stbuf_write_ack <= finish && req_write_q;
      bus_error           <= finish && !size_legal(size_q);
    end
  end

  // Byte-masked memory updates; word w on the first beat, word w+1 on the second.
  always_ff @(posedge clk) begin
    if (beat1_fire && req_write_q) begin
      for (int b = 0; b < BUS_BYTES; b++) begin
        if (be_lo[b]) mem[widx][8*b +: 8] <= wdata_lo[8*b +: 8];
      end
    end else if (beat2_fire && req_write_q) begin
      for (int b = 0; b < BUS_BYTES; b++) begin
        if (be_hi[b]) mem[widx_next][8*b +: 8] <= wdata_hi[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/stbuf_bus_responder.md
Name: stbuf_bus_responder

Overview:
- Memory-side responder for the store buffer's data-bus initiator port.
- Accepts read requests (uncommitted-load misses) and write requests (committed-store drains). Serves them from an internal byte-addressable little-endian memory with a programmable access latency.
- Returns one-cycle acks, plus read data on the read path.
- Sits between store_buffer and the data memory model; used in the core top and as the bus model in store-buffer-level benches.

Parameters:
- MEM_WORDS, 1024, number of REG_DATA_WIDTH-bit words in the memory (power of two).
- LATENCY, 2, cycles per memory word beat (legal 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stbuf_bus_read_addr  in  `ADDR_WIDTH  read byte address.
- stbuf_bus_read_size  in  `SIZE_WIDTH  read byte count.
- stbuf_bus_read_req  in  1  read request (level).
- stbuf_bus_write_addr  in  `ADDR_WIDTH  write byte address.
- stbuf_bus_write_size  in  `SIZE_WIDTH  write byte count.
- stbuf_bus_data  in  `REG_DATA_WIDTH  write data; LSB byte goes to the lowest address.
- stbuf_bus_write_req  in  1  write request (level).
- bus_stbuf_data  out  `REG_DATA_WIDTH  read data, right-aligned and zero-extended.
- bus_stbuf_read_ack  out  1  one-cycle read completion.
- bus_stbuf_write_ack  out  1  one-cycle write completion.
- bus_error  out  1  one-cycle pulse marking an illegal size, coincident with the ack.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - All acks and bus_error go to 0; bus_stbuf_data goes to 0.
  - The last-grant flag is cleared, so write wins the first tie.
  - Memory contents are not reset.
- Legal sizes are 1, 2 and 4 bytes.
  - Any other size still completes and acks, with bus_error=1.
  - In that case a write modifies nothing and a read returns 0.
- Word index = addr[log2(MEM_WORDS)+1:2]; upper address bits are ignored (aliasing).
- Split access: addr[1:0]+size > 4. It touches word w, then word (w+1) mod MEM_WORDS, which wraps to word 0 at the top.
- FSM states: IDLE, BEAT1, BEAT2, RESP.
- IDLE:
  - At an edge with any req high, latch addr, size, data and type, then go to BEAT1 with the counter at LATENCY-1.
  - If both reqs are high, grant the type not granted last (round-robin), then update the last-grant flag.
- BEAT1: count down. On reaching 0, do the word-w access, then:
  - go to BEAT2 if split (counter reloaded);
  - otherwise go to RESP.
- BEAT2: count down. On reaching 0, do the word-w+1 access, then go to RESP.
- Write beat: a byte-enable mask, derived from offset and size, merges into the memory word.
- Read beat: assembled bytes are registered into bus_stbuf_data.
- RESP:
  - The matching ack is high for exactly this cycle, and bus_stbuf_data is valid.
  - Next state is IDLE. req is not sampled at the edge leaving RESP.
- Latency:
  - An aligned request sampled at edge 0 acks in the cycle after edge L; a split request acks in the cycle after edge 2L.
  - Minimum request-to-request spacing is L+2 edges.
- bus_stbuf_data holds its last read value until the next read completes. Writes never change it.
- A request dropped after being sampled still completes and still acks. The initiator may ignore that ack.
- A request raised while busy waits; it is not queued beyond its level.
- Reset during BEAT2 of a split write leaves word w already written and word w+1 untouched. Reset during BEAT1 writes nothing.
- Acks are mutually exclusive and never high in consecutive cycles.

Decomposition:
- The shared package holds:
  - the enum stbuf_bus_resp_state_t {IDLE, BEAT1, BEAT2, RESP};
  - the constant BUS_BYTES = `REG_DATA_WIDTH/8;
  - the function size_legal(size).
- One sub-module, bus_lane_align (combinational), does both jobs:
  - computes the byte-enable masks and rotated write data for both beats from offset and size;
  - assembles read bytes from the two words.
- Top block: FSM, latency counter, arbiter, memory array.

Test Plan:
- Aligned write, then read:
  - Stimulus: write addr 0x0, size 4, data 0xaabbccdd; then read addr 0x0, size 4.
  - Response: write_ack in the cycle after edge 2; read returns 0xaabbccdd; bus_error=0.
- Subword merge:
  - Stimulus: after the write above, write addr 0x1, size 1, data 0x3f; then read addr 0x0, size 4.
  - Response: 0xaabb3fdd. Reading addr 0x2, size 2 returns 0x0000aabb.
- Split access:
  - Stimulus: write addr 0x2, size 4, data 0x11223344.
  - Response: ack in the cycle after edge 4 (2L). Read addr 0x0, size 4 gives 0x3344xxxx (low half as before); read addr 0x4, size 2 gives 0x1122.
  - Wrap: the same pattern at the top word of memory updates word 0.
- Simultaneous requests:
  - Stimulus: read_req and write_req raised together and held.
  - Response: write granted first, then read. The read sees the new data. Acks are never adjacent and the spacing is at least L+2.
- Illegal size and reset:
  - Stimulus: write size 3.
  - Response: write_ack with bus_error=1; memory unchanged.
  - Stimulus: assert rst low in BEAT1 of a write.
  - Response: no ack; bus_stbuf_data=0; a subsequent read shows the old data.
